// File: rtl/lsu_byte_master.sv
// lsu_byte_master
// Load/store initiator sitting between the pipeline memory stage and a
// byte-wide synchronous data RAM. One request is accepted at a time and is
// split into 1, 2 or 4 sequential byte accesses. Byte order is big-endian:
// the lowest address holds the most significant byte. Load data is assembled
// and sign/zero extended into a single response. A legal load from TRIG_ADDR
// returns the external trigger bit instead of touching RAM.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        request handshake (ready only while IDLE)
//   req_we, req_mode           store/load select, access size/extension mode
//   req_addr, req_wdata        byte address, store data (low 8*N bits used)
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       extended load data, illegal-mode flag
//   trigger                    external status bit for TRIG_ADDR loads
//   mem_en/mem_we              RAM strobe and write enable
//   mem_addr/mem_wdata         RAM byte address and write byte
//   mem_rdata                  RAM read byte, valid the cycle after a strobe
module lsu_byte_master #(
    parameter int                 WIDTH     = 32,
    parameter int                 MEM_AW    = 17,
    parameter logic [WIDTH-1:0]   TRIG_ADDR = 32'h100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_mode,
    input  logic [WIDTH-1:0]  req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              resp_valid,
    output logic [WIDTH-1:0]  resp_rdata,
    output logic              resp_err,
    input  logic              trigger,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic               req_ready_r;
    logic [1:0]         cnt_r;
    logic [1:0]         last_r;
    logic               we_r;
    logic [2:0]         mode_r;
    logic [31:0]        wsh_r;
    logic [31:0]        asm_r;
    logic               mem_en_r;
    logic               mem_we_r;
    logic [MEM_AW-1:0]  mem_addr_r;
    logic [7:0]         mem_wdata_r;
    logic               resp_valid_r;
    logic [WIDTH-1:0]   resp_rdata_r;
    logic               resp_err_r;

    logic               accept_s;
    logic               legal_s;
    logic               trig_s;
    logic [31:0]        wsh_s;
    logic [31:0]        asm_full_s;

    // Legal access modes: word, half, byte, unsigned half, unsigned byte.
    function automatic logic mode_legal(input logic [2:0] mode);
        case (mode)
            3'b001, 3'b010, 3'b011, 3'b100, 3'b101: mode_legal = 1'b1;
            default:                                mode_legal = 1'b0;
        endcase
    endfunction

    // Index of the last byte access (N-1).
    function automatic logic [1:0] last_idx(input logic [2:0] mode);
        case (mode)
            3'b001:         last_idx = 2'd3;
            3'b010, 3'b100: last_idx = 2'd1;
            default:        last_idx = 2'd0;
        endcase
    endfunction

    // Left-align the N store bytes so the most significant one sits in [31:24].
    function automatic logic [31:0] store_align(input logic [2:0] mode, input logic [31:0] wd);
        case (mode)
            3'b001:         store_align = wd;
            3'b010, 3'b100: store_align = {wd[15:0], 16'h0000};
            default:        store_align = {wd[7:0], 24'h000000};
        endcase
    endfunction

    // Sign/zero extension of the assembled big-endian load value.
    function automatic logic [WIDTH-1:0] load_extend(input logic [2:0] mode, input logic [31:0] v);
        case (mode)
            3'b001:  load_extend = WIDTH'(v);
            3'b010:  load_extend = WIDTH'($signed(v[15:0]));
            3'b011:  load_extend = WIDTH'($signed(v[7:0]));
            3'b100:  load_extend = WIDTH'(v[15:0]);
            3'b101:  load_extend = WIDTH'(v[7:0]);
            default: load_extend = {WIDTH{1'b0}};
        endcase
    endfunction

    assign accept_s   = req_valid && req_ready_r && (state_r == IDLE);
    assign legal_s    = mode_legal(req_mode);
    assign trig_s     = legal_s && !req_we && (req_addr == TRIG_ADDR);
    assign wsh_s      = store_align(req_mode, req_wdata[31:0]);
    // The byte arriving this cycle completes the shift into the assembly register.
    assign asm_full_s = {asm_r[23:0], mem_rdata};

    // Next-state decode for the request sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (!legal_s || trig_s) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = ISSUE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (cnt_r == last_r) begin
                    state_next_s = we_r ? RESP : DRAIN;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            DRAIN:   state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register plus registered datapath and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            cnt_r        <= 2'd0;
            last_r       <= 2'd0;
            we_r         <= 1'b0;
            mode_r       <= 3'b000;
            wsh_r        <= 32'h0000_0000;
            asm_r        <= 32'h0000_0000;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {MEM_AW{1'b0}};
            mem_wdata_r  <= 8'h00;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {WIDTH{1'b0}};
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            req_ready_r  <= (state_next_s == IDLE);
            resp_valid_r <= 1'b0;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r   <= req_we;
                        mode_r <= req_mode;
                        last_r <= last_idx(req_mode);
                        cnt_r  <= 2'd0;
                        asm_r  <= 32'h0000_0000;
                        if (!legal_s) begin
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= {WIDTH{1'b0}};
                        end else if (trig_s) begin
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b0;
                            resp_rdata_r <= {{(WIDTH-1){1'b0}}, trigger};
                        end else begin
                            mem_en_r    <= 1'b1;
                            mem_we_r    <= req_we;
                            mem_addr_r  <= req_addr[MEM_AW-1:0];
                            mem_wdata_r <= wsh_s[31:24];
                            wsh_r       <= {wsh_s[23:0], 8'h00};
                        end
                    end
                end
                ISSUE: begin
                    // From the second access on, the previous strobe's data is on mem_rdata.
                    if ((cnt_r != 2'd0) && !we_r) begin
                        asm_r <= asm_full_s;
                    end
                    if (cnt_r == last_r) begin
                        if (we_r) begin
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b0;
                            resp_rdata_r <= {WIDTH{1'b0}};
                        end
                    end else begin
                        cnt_r       <= cnt_r + 2'd1;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= we_r;
                        mem_addr_r  <= mem_addr_r + {{(MEM_AW-1){1'b0}}, 1'b1};
                        mem_wdata_r <= wsh_r[31:24];
                        wsh_r       <= {wsh_r[23:0], 8'h00};
                    end
                end
                DRAIN: begin
                    asm_r        <= asm_full_s;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= load_extend(mode_r, asm_full_s);
                end
                RESP: begin
                    cnt_r <= 2'd0;
                end
                default: begin
                    cnt_r <= 2'd0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_en     = mem_en_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_lsu_byte_master.sv
// Directed testbench for lsu_byte_master with a byte-wide synchronous RAM model.
module tb_lsu_byte_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        trigger;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [0:131071];

    int          total;
    int          bad;
    int          lat;
    int          n_mem;
    int          n_we;
    logic [31:0] r_data;
    logic        r_err;
    logic [16:0] a_log [8];
    logic [7:0]  d_log [8];

    lsu_byte_master #(.WIDTH(32), .MEM_AW(17), .TRIG_ADDR(32'h100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_mode   (req_mode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .trigger    (trigger),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous byte RAM: write on strobe+we, otherwise read data next cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then log RAM activity per cycle until the response.
    task automatic run_req(input logic we, input logic [2:0] mode,
                           input logic [31:0] addr, input logic [31:0] wd);
        int waited;
        @(negedge clk);
        req_we    = we;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_mem  = 0;
        n_we   = 0;
        lat    = 0;
        r_data = 32'hxxxx_xxxx;
        r_err  = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_en) begin
                if (n_mem < 8) begin
                    a_log[n_mem] = mem_addr;
                    d_log[n_mem] = mem_wdata;
                end
                n_mem++;
                if (mem_we) n_we++;
            end
            if (resp_valid) begin
                lat    = c;
                r_data = resp_rdata;
                r_err  = resp_err;
                break;
            end
        end
    endtask

    logic [31:0] exp_w;
    logic [7:0]  rdy_mask;
    logic [7:0]  rsp_mask;
    int          seen;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_mode  = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        trigger   = 1'b0;
        mem_rdata = 8'h00;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_flags", 32'({resp_valid, resp_err, mem_en, mem_we}), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_maddr", 32'({mem_addr, mem_wdata}), 32'd0);
        rst_n = 1'b1;

        // Word store, MSB first.
        run_req(1'b1, 3'b001, 32'h40, 32'hDEADBEEF);
        chk("st_w_lat", 32'(lat), 32'd5);
        chk("st_w_rdata", r_data, 32'd0);
        chk("st_w_err", 32'(r_err), 32'd0);
        chk("st_w_nmem", 32'(n_mem), 32'd4);
        chk("st_w_nwe", 32'(n_we), 32'd4);
        exp_w = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            chk("st_w_addr", 32'(a_log[k]), 32'h40 + 32'(k));
            chk("st_w_data", 32'(d_log[k]), 32'(exp_w[31:24]));
            exp_w = exp_w << 8;
        end

        // Word load back.
        run_req(1'b0, 3'b001, 32'h40, 32'h0);
        chk("ld_w_lat", 32'(lat), 32'd6);
        chk("ld_w_data", r_data, 32'hDEADBEEF);
        chk("ld_w_nwe", 32'(n_we), 32'd0);

        // Half store F123 at 0x80 -> 0x80=F1, 0x81=23.
        run_req(1'b1, 3'b010, 32'h80, 32'h5555F123);
        chk("st_h_lat", 32'(lat), 32'd3);
        chk("st_h_nwe", 32'(n_we), 32'd2);
        chk("st_h_d0", 32'(d_log[0]), 32'hF1);
        chk("st_h_d1", 32'(d_log[1]), 32'h23);

        // Signed and unsigned loads.
        run_req(1'b0, 3'b010, 32'h80, 32'h0);
        chk("ld_h_lat", 32'(lat), 32'd4);
        chk("ld_h_data", r_data, 32'hFFFFF123);
        run_req(1'b0, 3'b100, 32'h80, 32'h0);
        chk("ld_hu_data", r_data, 32'h0000F123);
        run_req(1'b0, 3'b011, 32'h80, 32'h0);
        chk("ld_b_lat", 32'(lat), 32'd3);
        chk("ld_b_data", r_data, 32'hFFFFFFF1);
        run_req(1'b0, 3'b101, 32'h80, 32'h0);
        chk("ld_bu_data", r_data, 32'h000000F1);
        run_req(1'b0, 3'b011, 32'h81, 32'h0);
        chk("ld_b_pos", r_data, 32'h00000023);

        // Trigger load and illegal modes.
        trigger = 1'b1;
        run_req(1'b0, 3'b001, 32'h100, 32'h0);
        chk("trig_lat", 32'(lat), 32'd1);
        chk("trig_data", r_data, 32'h00000001);
        chk("trig_err", 32'(r_err), 32'd0);
        chk("trig_nmem", 32'(n_mem), 32'd0);
        trigger = 1'b0;
        run_req(1'b0, 3'b101, 32'h100, 32'h0);
        chk("trig0_data", r_data, 32'h00000000);
        chk("trig0_nmem", 32'(n_mem), 32'd0);
        run_req(1'b0, 3'b110, 32'h80, 32'h0);
        chk("err_lat", 32'(lat), 32'd1);
        chk("err_flag", 32'(r_err), 32'd1);
        chk("err_data", r_data, 32'd0);
        chk("err_nmem", 32'(n_mem), 32'd0);
        run_req(1'b1, 3'b000, 32'h80, 32'h12345678);
        chk("err_st_flag", 32'(r_err), 32'd1);
        chk("err_st_nmem", 32'(n_mem), 32'd0);

        // Address wrap on store and load.
        run_req(1'b1, 3'b001, 32'h1FFFE, 32'h11223344);
        chk("wrap_st_nwe", 32'(n_we), 32'd4);
        run_req(1'b0, 3'b001, 32'h1FFFE, 32'h0);
        chk("wrap_a0", 32'(a_log[0]), 32'h1FFFE);
        chk("wrap_a1", 32'(a_log[1]), 32'h1FFFF);
        chk("wrap_a2", 32'(a_log[2]), 32'h00000);
        chk("wrap_a3", 32'(a_log[3]), 32'h00001);
        chk("wrap_lat", 32'(lat), 32'd6);
        chk("wrap_data", r_data, 32'h11223344);

        // Asynchronous reset pulse in the middle of a cycle.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rdata", resp_rdata, 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_mem", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
        #1 rst_n = 1'b1;

        // Reset during the ISSUE phase of a word load.
        @(negedge clk);
        req_we    = 1'b0;
        req_mode  = 3'b001;
        req_addr  = 32'h40;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("issue_en", 32'(mem_en), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("issue_rst_en", 32'(mem_en), 32'd0);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("issue_rst_noresp", 32'(seen), 32'd0);

        // Back-to-back with req_valid held high.
        @(negedge clk);
        req_we    = 1'b0;
        req_mode  = 3'b101;
        req_addr  = 32'h80;
        req_valid = 1'b1;
        rdy_mask  = 8'h00;
        rsp_mask  = 8'h00;
        rdy_mask[0] = req_ready;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            rdy_mask[c] = req_ready;
            rsp_mask[c] = resp_valid;
        end
        req_valid = 1'b0;
        chk("b2b_ready", 32'(rdy_mask), 32'h11);
        chk("b2b_resp", 32'(rsp_mask), 32'h88);
        chk("b2b_data", resp_rdata, 32'h000000F1);
        repeat (3) @(negedge clk);
        chk("b2b_idle", 32'(req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
